// File: rtl/ov7670_sccb_master_if.sv
// Request/bus bundle for the OV7670 SCCB write master.
// The requester raises start with data; a request is taken only while busy=0. done is a one-cycle pulse when the write ends.
interface ov7670_sccb_master_if;
  logic        start;
  logic [15:0] data;
  logic        busy;
  logic        done;
  logic        sioc;
  logic        siod_out;
  logic        siod_oe;

  // Requester side (init sequencer).
  modport master (
    output start, data,
    input  busy, done, sioc, siod_out, siod_oe
  );

  // Serving side (the SCCB engine).
  modport slave (
    input  start, data,
    output busy, done, sioc, siod_out, siod_oe
  );
endinterface

// File: rtl/ov7670_sccb_master.sv
// SCCB 3-phase write engine for the OV7670: START, 27 bits (ID, reg, value, each with a
// don't-care bit), STOP, then an idle gap before done.
module ov7670_sccb_master #(
  parameter int          CLK_DIV      = 125,
  parameter logic [7:0]  DEVICE_ID    = 8'h42,
  parameter int          GAP_QUARTERS = 400
) (
  input  logic                       clk,
  input  logic                       reset_n,
  ov7670_sccb_master_if.slave        bus,
  output logic [2:0]                 dbg_state
);

  typedef enum logic [2:0] {IDLE, START, BITS, STOP, GAP} state_t;

  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_MAX = (GAP_QUARTERS > 26) ? GAP_QUARTERS : 26;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t          state, state_n;
  logic [DW-1:0]   div_cnt, div_n;
  logic [1:0]      q, q_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [15:0]     data_q, data_n;
  logic            done_q, done_n;
  logic            sioc_q, sioc_n;
  logic            siod_q, siod_n;
  logic            oe_q, oe_n;
  logic            tick;
  logic [26:0]     frame;
  logic [4:0]      bit_idx;
  logic            is_x;

  assign tick  = (div_cnt == DW'(CLK_DIV - 1));
  // X positions carry 1 so the released (pulled-up) level matches the driven value.
  assign frame = {DEVICE_ID, 1'b1, data_q[15:8], 1'b1, data_q[7:0], 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      q       <= '0;
      cnt     <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      sioc_q  <= 1'b1;
      siod_q  <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      q       <= q_n;
      cnt     <= cnt_n;
      data_q  <= data_n;
      done_q  <= done_n;
      sioc_q  <= sioc_n;
      siod_q  <= siod_n;
      oe_q    <= oe_n;
    end
  end

  // Outputs are decoded from the next state/quarter so the registered pins line up with the quarter they describe.
  always_comb begin
    state_n = state;
    div_n   = tick ? '0 : div_cnt + DW'(1);
    q_n     = q;
    cnt_n   = cnt;
    data_n  = data_q;
    done_n  = 1'b0;
    sioc_n  = 1'b1;
    siod_n  = 1'b0;
    oe_n    = 1'b0;
    bit_idx = '0;
    is_x    = 1'b0;

    case (state)
      IDLE: begin
        div_n = '0;
        if (bus.start && bus.data != 16'hFFFF) begin
          state_n = START;
          q_n     = '0;
          cnt_n   = '0;
          data_n  = bus.data;
        end
      end
      GAP: begin
        if (tick) begin
          if (cnt == CW'(GAP_QUARTERS - 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
            cnt_n   = '0;
            q_n     = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: begin
        if (tick) begin
          q_n = q + 2'd1;
          if (q == 2'd3) begin
            case (state)
              START: begin
                state_n = BITS;
                cnt_n   = '0;
              end
              BITS: begin
                if (cnt == CW'(26)) begin
                  state_n = STOP;
                  cnt_n   = '0;
                end else begin
                  cnt_n = cnt + CW'(1);
                end
              end
              default: begin
                state_n = GAP;
                cnt_n   = '0;
              end
            endcase
          end
        end
      end
    endcase

    bit_idx = 5'd26 - cnt_n[4:0];
    is_x    = (cnt_n == CW'(8)) || (cnt_n == CW'(17)) || (cnt_n == CW'(26));

    case (state_n)
      START: begin
        oe_n   = 1'b1;
        siod_n = (q_n == 2'd0);
        sioc_n = (q_n != 2'd3);
      end
      BITS: begin
        sioc_n = q_n[1];
        siod_n = frame[bit_idx];
        oe_n   = !is_x;
      end
      STOP: begin
        sioc_n = (q_n != 2'd0);
        siod_n = (q_n == 2'd2);
        oe_n   = (q_n != 2'd3);
      end
      default: ;
    endcase
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.sioc     = sioc_q;
  assign bus.siod_out = siod_q;
  assign bus.siod_oe  = oe_q;
  assign dbg_state    = state;

endmodule

// File: doc/ov7670_sccb_master.md
OV7670_SCCB_MASTER -- requirements
Module: ov7670_sccb_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, meaning clk cycles per quarter SIOC period; legal range is at least 2.
REQ-002 SHALL have parameter DEVICE_ID, default 8'h42, meaning the OV7670 SCCB write ID byte.
REQ-003 SHALL have parameter GAP_QUARTERS, default 400, meaning idle quarter-periods inserted after STOP before done.
REQ-004 SHALL have port clk, input, 1 bit, meaning core clock.
REQ-005 SHALL have port reset_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit, meaning request a 3-phase write of data.
REQ-007 SHALL have port data, input, 16 bits, meaning {REG_ADDR, REG_VALUE}.
REQ-008 SHALL have port busy, output, 1 bit, meaning a transaction is in progress.
REQ-009 SHALL have port done, output, 1 bit, meaning one-cycle pulse at the end of a transaction; it drives the init sequencer's continue input.
REQ-010 SHALL have port sioc, output, 1 bit, meaning SCCB clock.
REQ-011 SHALL have port siod_out, output, 1 bit, meaning SCCB data drive value.
REQ-012 SHALL have port siod_oe, output, 1 bit, meaning SCCB data output enable; the line is pulled up when released.

Function
REQ-013 SHALL implement FSM states IDLE, START, BITS, STOP and GAP.
REQ-014 SHALL, in IDLE with start=1 and data!=16'hFFFF, latch data, clear the quarter divider and enter START on the same edge; busy SHALL be 1 from the next cycle.
REQ-015 SHALL ignore start when data==16'hFFFF (end-of-table marker): stay in IDLE, no done pulse.
REQ-016 SHALL ignore start when not in IDLE; latched data SHALL be unaffected.
REQ-017 SHALL generate the quarter tick when the divider count reaches CLK_DIV-1, then wrap the count to 0; each phase spans 4 ticks q0..q3.
REQ-018 SHALL drive START as follows: q0 sioc=1, siod=1; q1 and q2 sioc=1, siod=0; q3 sioc=0, siod=0.
REQ-019 SHALL shift 27 bits MSB first in BITS: DEVICE_ID, X, data[15:8], X, data[7:0], X.
REQ-020 SHALL, per bit, update siod at q0 with sioc=0; hold sioc=0 at q1; hold sioc=1 at q2 and q3.
REQ-021 SHALL hold siod_oe=0 for the full 4 quarters of each X bit; slave ACK is not checked.
REQ-022 SHALL drive STOP as follows: q0 sioc=0, siod=0; q1 sioc=1, siod=0; q2 sioc=1, siod=1; q3 siod_oe=0.
REQ-023 SHALL, in GAP, keep sioc=1 and siod_oe=0 for GAP_QUARTERS ticks, then enter IDLE.
REQ-024 SHALL pulse done=1 for exactly the first IDLE cycle after GAP, with busy=0 in that cycle.
REQ-025 SHALL accept a start arriving in the done cycle.
REQ-026 SHALL make the total transaction length, from the accept edge to the done cycle, (116+GAP_QUARTERS)*CLK_DIV clk cycles.
REQ-027 SHALL hold sioc=1, siod_oe=0 and siod_out=0 in IDLE.
REQ-028 SHALL register sioc, siod_out and siod_oe with no combinational path from start or data.

Reset
REQ-029 SHALL, while reset_n=0, hold state=IDLE, busy=0, done=0, sioc=1, siod_oe=0, siod_out=0, divider=0, bit counter=0 and latched data=0.
REQ-030 SHALL, on reset asserted mid-transaction, release the bus immediately and issue no done pulse.
REQ-031 SHALL, after reset_n deasserts, wait for a new start before starting any transaction.

Verification (CLK_DIV=4, GAP_QUARTERS=8)
REQ-032 SHALL verify: start with data=16'h1280 in IDLE -> SIOD bit sequence 0x42,X,0x12,X,0x80,X; done asserted 496 cycles after accept; busy high throughout.
REQ-033 SHALL verify: start with data=16'hFFFF -> busy stays 0, no done, sioc stays 1 for 1000 cycles.
REQ-034 SHALL verify: start pulsed again 50 cycles into a transaction -> ignored; the second word is never transmitted; a single done pulse occurs.
REQ-035 SHALL verify: start held high through done with data=16'h1101 -> a second transaction begins on the done cycle, and the next done occurs 496 cycles later.
REQ-036 SHALL verify: reset_n=0 at cycle 200 of a transaction -> same-cycle sioc=1 and siod_oe=0, no done; a new start after release sends a complete frame.
REQ-037 SHALL verify: bench SIOD monitor -> siod changes only while sioc=0, except the START and STOP edges, and siod_oe=0 for each X bit.
